// File: rtl/wrr_sched_pkg.sv
// wrr_sched_pkg: scheduler state type and round-robin pointer increment helper
package wrr_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} sched_state_e;
  function automatic int ptr_inc(input int p, input int n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/wrr_tenure_sched_if.sv
// wrr_tenure_sched_if: client bundle (i_req/i_lock/i_weight/i_cfg_load/i_beat_done in, o_gnt/o_gnt_id/o_busy/o_lock_timeout out)
interface wrr_tenure_sched_if #(
  parameter int NUM_CLIENTS  = 4,
  parameter int WEIGHT_WIDTH = 4
);
  logic [NUM_CLIENTS-1:0]              i_req;
  logic [NUM_CLIENTS-1:0]              i_lock;
  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] i_weight;
  logic                                i_cfg_load;
  logic                                i_beat_done;
  logic [NUM_CLIENTS-1:0]              o_gnt;
  logic [$clog2(NUM_CLIENTS)-1:0]      o_gnt_id;
  logic                                o_busy;
  logic                                o_lock_timeout;
  modport master (
    output i_req, i_lock, i_weight, i_cfg_load, i_beat_done,
    input  o_gnt, o_gnt_id, o_busy, o_lock_timeout
  );
  modport slave (
    input  i_req, i_lock, i_weight, i_cfg_load, i_beat_done,
    output o_gnt, o_gnt_id, o_busy, o_lock_timeout
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, first set req bit scanning from ptr upward (req, ptr in; found, idx out)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  always_comb begin
    found = |req;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      idx = req[j] ? j : idx;
    end
  end
endmodule

// File: rtl/wrr_tenure_sched.sv
// wrr_tenure_sched: weighted round-robin tenure scheduler with lock extension and watchdog (clk, rst_n, bus slave)
module wrr_tenure_sched
  import wrr_sched_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MAX_HOLD     = 16
) (
  input logic clk,
  input logic rst_n,
  wrr_tenure_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  sched_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_id_q, gnt_id_d, win;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d, w;
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [NUM_CLIENTS-1:0][WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic to_q, to_d, found, own_req, own_lock, rel;
  rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req  (bus.i_req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (win)
  );
  assign own_req  = bus.i_req[gnt_id_q];
  assign own_lock = bus.i_lock[gnt_id_q];
  assign bus.o_gnt = gnt_q;
  assign bus.o_gnt_id = gnt_id_q;
  assign bus.o_busy = state_q != IDLE;
  assign bus.o_lock_timeout = to_q;
  always_comb begin
    weight_d = weight_q;
    w = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      w = bus.i_weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      weight_d[k] = bus.i_cfg_load ? ((w == '0) ? WEIGHT_WIDTH'(1) : w) : weight_q[k];
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_id_d = gnt_id_q;
    credit_d = credit_q;
    hold_d = hold_q;
    gnt_d = gnt_q;
    to_d = 1'b0;
    rel = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_id_d = win;
        gnt_d = NUM_CLIENTS'(1) << win;
        credit_d = weight_q[win];
        hold_d = '0;
      end
      GRANT: begin
        credit_d = credit_q - WEIGHT_WIDTH'(bus.i_beat_done);
        if ((bus.i_beat_done && credit_q == WEIGHT_WIDTH'(1)) || !own_req) begin
          state_d = own_lock ? LOCKED : state_q;
          credit_d = own_lock ? '0 : credit_d;
          rel = !own_lock;
        end
      end
      LOCKED: begin
        hold_d = hold_q + HW'(1);
        to_d = own_lock && hold_q == HW'(MAX_HOLD - 1);
        rel = !own_lock || to_d;
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d = IDLE;
      gnt_d = '0;
      ptr_d = IW'(ptr_inc(int'(gnt_id_q), NUM_CLIENTS));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
      hold_q <= '0;
      gnt_q <= '0;
      to_q <= 1'b0;
      weight_q <= {NUM_CLIENTS{WEIGHT_WIDTH'(1)}};
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_id_q <= gnt_id_d;
      credit_q <= credit_d;
      hold_q <= hold_d;
      gnt_q <= gnt_d;
      to_q <= to_d;
      weight_q <= weight_d;
    end
  end
endmodule

// File: tb/tb_wrr_tenure_sched.sv
// tb_wrr_tenure_sched: vector table, directed corner sequences and randomized run against a tenure-level model
module tb_wrr_tenure_sched;
  localparam int N = 4, W = 4, MH = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  wrr_tenure_sched_if #(.NUM_CLIENTS(N), .WEIGHT_WIDTH(W)) bus ();
  wrr_tenure_sched #(.NUM_CLIENTS(N), .WEIGHT_WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  typedef struct {
    logic [3:0]  req, lock;
    logic        beat, cfg;
    logic [15:0] w;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        busy, to;
  } vec_t;
  vec_t tbl[20];
  int tests = 0, fails = 0;
  int m_own, m_ptr, m_left, m_lcyc, m_wt[N];
  bit m_lk, m_to;
  function automatic vec_t mk(input logic [3:0] req, lock, input logic beat, cfg, input logic [15:0] w,
                              input logic [3:0] gnt, input logic [1:0] id, input logic busy, to);
    vec_t v;
    v.req = req; v.lock = lock; v.beat = beat; v.cfg = cfg; v.w = w;
    v.gnt = gnt; v.id = id; v.busy = busy; v.to = to;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [3:0] req, lock, input logic beat, cfg, input logic [15:0] w);
    bus.i_req = req; bus.i_lock = lock; bus.i_beat_done = beat; bus.i_cfg_load = cfg; bus.i_weight = w;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    drive(4'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic m_release;
    m_ptr = (m_own + 1) % N;
    m_own = -1;
    m_lk = 0;
  endtask
  task automatic model_step(input logic [3:0] req, lock, input logic beat, cfg, input logic [15:0] w);
    m_to = 0;
    if (m_own < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_own < 0 && req[(m_ptr + i) % N]) begin
          m_own = (m_ptr + i) % N;
          m_left = m_wt[m_own];
          m_lk = 0;
        end
      end
    end else if (!m_lk) begin
      if (beat) m_left--;
      if ((beat && m_left == 0) || !req[m_own]) begin
        if (lock[m_own]) begin
          m_lk = 1;
          m_lcyc = 0;
        end else m_release();
      end
    end else begin
      m_lcyc++;
      if (!lock[m_own]) m_release();
      else if (m_lcyc == MH) begin
        m_release();
        m_to = 1;
      end
    end
    if (cfg) for (int k = 0; k < N; k++) m_wt[k] = (w[k*4 +: 4] == 0) ? 1 : int'(w[k*4 +: 4]);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int held, to_cnt;
    bit got1;
    logic [3:0] rq, lk;
    logic bt, cf;
    logic [15:0] wv;
    tbl[0]  = mk(4'h0, 4'h0, 0, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[1]  = mk(4'h4, 4'h0, 0, 0, 16'h0,    4'h4, 2'd2, 1, 0);
    tbl[2]  = mk(4'h4, 4'h0, 1, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[3]  = mk(4'h0, 4'h0, 0, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[4]  = mk(4'h0, 4'h0, 0, 1, 16'h1131, 4'h0, 2'd0, 0, 0);
    tbl[5]  = mk(4'h2, 4'h0, 0, 0, 16'h0,    4'h2, 2'd1, 1, 0);
    tbl[6]  = mk(4'h2, 4'h0, 1, 0, 16'h0,    4'h2, 2'd1, 1, 0);
    tbl[7]  = mk(4'h0, 4'h0, 0, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[8]  = mk(4'hF, 4'h0, 0, 0, 16'h0,    4'h4, 2'd2, 1, 0);
    tbl[9]  = mk(4'hF, 4'h0, 1, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[10] = mk(4'hF, 4'h0, 0, 0, 16'h0,    4'h8, 2'd3, 1, 0);
    tbl[11] = mk(4'hF, 4'h0, 1, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[12] = mk(4'hF, 4'h1, 0, 0, 16'h0,    4'h1, 2'd0, 1, 0);
    tbl[13] = mk(4'hF, 4'h1, 1, 0, 16'h0,    4'h1, 2'd0, 1, 0);
    for (int i = 14; i < 18; i++) tbl[i] = mk(4'hF, 4'h1, 0, 0, 16'h0, 4'h1, 2'd0, 1, 0);
    tbl[18] = mk(4'hF, 4'h0, 0, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    tbl[19] = mk(4'h0, 4'h0, 0, 0, 16'h0,    4'h0, 2'd0, 0, 0);
    do_reset();
    chk("reset_gnt", bus.o_gnt, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_id", bus.o_gnt_id, 0);
    chk("reset_to", bus.o_lock_timeout, 0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].beat, tbl[i].cfg, tbl[i].w);
      tick();
      chk($sformatf("tbl%0d_gnt", i), bus.o_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), bus.o_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_to", i), bus.o_lock_timeout, tbl[i].to);
      if (tbl[i].busy) chk($sformatf("tbl%0d_id", i), bus.o_gnt_id, tbl[i].id);
    end
    do_reset();
    drive(4'h0, 4'h0, 0, 1, 16'h4321);
    tick();
    drive(4'hF, 4'h0, 1, 0, 16'h0);
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c <= t % 4; c++) begin
        tick();
        chk($sformatf("wrr_t%0d_busy", t), bus.o_busy, 1);
        chk($sformatf("wrr_t%0d_id", t), bus.o_gnt_id, t % 4);
      end
      tick();
      chk($sformatf("wrr_t%0d_gap", t), bus.o_busy, 0);
    end
    do_reset();
    drive(4'h1, 4'h1, 0, 0, 16'h0);
    tick();
    chk("to_grant", bus.o_gnt, 4'h1);
    drive(4'h3, 4'h1, 1, 0, 16'h0);
    tick();
    chk("to_locked", bus.o_gnt, 4'h1);
    drive(4'h3, 4'h1, 0, 0, 16'h0);
    held = 2; to_cnt = 0; got1 = 0;
    for (int i = 0; i < 40 && !got1; i++) begin
      tick();
      if (bus.o_gnt == 4'h1) held++;
      if (bus.o_lock_timeout) begin
        to_cnt++;
        chk("to_pulse_gnt", bus.o_gnt, 0);
      end
      if (bus.o_gnt == 4'h2) got1 = 1;
    end
    chk("to_held_cycles", held, 17);
    chk("to_pulse_count", to_cnt, 1);
    chk("to_next_grant", got1, 1);
    do_reset();
    drive(4'h0, 4'h0, 0, 1, 16'h3333);
    tick();
    drive(4'h8, 4'h0, 0, 0, 16'h0);
    tick();
    chk("cfg_grant_id", bus.o_gnt_id, 3);
    drive(4'h8, 4'h0, 1, 1, 16'h0333);
    tick();
    chk("cfg_beat1_busy", bus.o_busy, 1);
    drive(4'h8, 4'h0, 1, 0, 16'h0);
    tick();
    chk("cfg_beat2_busy", bus.o_busy, 1);
    tick();
    chk("cfg_beat3_rel", bus.o_busy, 0);
    tick();
    chk("cfg_regrant", bus.o_gnt, 4'h8);
    tick();
    chk("cfg_w0_one_beat", bus.o_busy, 0);
    do_reset();
    drive(4'h4, 4'h0, 0, 0, 16'h0);
    tick();
    drive(4'h4, 4'h0, 1, 0, 16'h0);
    tick();
    chk("rst_pre_rel", bus.o_busy, 0);
    drive(4'h8, 4'h8, 0, 0, 16'h0);
    tick();
    chk("rst_pre_id", bus.o_gnt_id, 3);
    drive(4'h8, 4'h8, 1, 0, 16'h0);
    tick();
    drive(4'h8, 4'h8, 0, 0, 16'h0);
    tick();
    chk("rst_pre_locked", bus.o_gnt, 4'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", bus.o_gnt, 0);
    chk("rst_mid_busy", bus.o_busy, 0);
    chk("rst_mid_id", bus.o_gnt_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'hF, 4'h0, 0, 0, 16'h0);
    tick();
    chk("rst_ptr_zero", bus.o_gnt, 4'h1);
    do_reset();
    m_own = -1; m_ptr = 0; m_lk = 0; m_to = 0; m_left = 0; m_lcyc = 0;
    for (int k = 0; k < N; k++) m_wt[k] = 1;
    lk = 4'h0;
    rq = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) lk = 4'($urandom_range(0, 15));
      bt = 1'($urandom_range(0, 1));
      cf = $urandom_range(0, 31) == 0;
      wv = 16'($urandom);
      drive(rq, lk, bt, cf, wv);
      @(posedge clk);
      model_step(rq, lk, bt, cf, wv);
      #1;
      chk("rnd_gnt", bus.o_gnt, (m_own >= 0) ? (4'h1 << m_own) : 4'h0);
      chk("rnd_busy", bus.o_busy, m_own >= 0);
      chk("rnd_to", bus.o_lock_timeout, m_to);
      if (m_own >= 0) chk("rnd_id", bus.o_gnt_id, m_own);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wrr_tenure_sched.md
# wrr_tenure_sched

Weighted round-robin tenure scheduler sharing one downstream port among NUM_CLIENTS requesters. A client wins a tenure, keeps a registered one-hot grant for up to weight beats (counted on `i_beat_done`), and can extend the tenure with its lock line. A watchdog force-releases a lock after MAX_HOLD cycles. The block sits between the client request/lock bundle and the shared datapath mux, and drives that mux select.

## Interface
- NUM_CLIENTS, 4, number of requesters (≥2)
- WEIGHT_WIDTH, 4, bits per client weight
- MAX_HOLD, 16, max cycles spent in LOCKED before forced release (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_CLIENTS  per-client request level
- i_lock  in  NUM_CLIENTS  per-client lock; only the owner's bit is observed
- i_weight  in  NUM_CLIENTS*WEIGHT_WIDTH  client k at bits [k*W +: W]
- i_cfg_load  in  1  single-cycle pulse; copies i_weight into the weight registers
- i_beat_done  in  1  downstream accepted one beat from the current owner
- o_gnt  out  NUM_CLIENTS  one-hot grant, registered
- o_gnt_id  out  $clog2(NUM_CLIENTS)  owner index, valid while o_busy
- o_busy  out  1  a tenure is active (state ≠ IDLE)
- o_lock_timeout  out  1  single-cycle pulse on forced release

## Operation
- State machine has three states: IDLE, GRANT, LOCKED.
- Registers:
  - weight[k]: reset value 1. i_cfg_load writes it; a weight of 0 is stored as 1.
  - ptr: round-robin start index, reset value 0.
  - credit: WEIGHT_WIDTH bits.
  - hold_cnt: $clog2(MAX_HOLD+1) bits.
- IDLE:
  - If i_req is nonzero, the winner is the first requesting index scanning ptr, ptr+1, … modulo NUM_CLIENTS.
  - Load credit ← weight[winner] and hold_cnt ← 0, then go to GRANT.
  - If i_req is zero, stay in IDLE.
- GRANT:
  - Each i_beat_done decrements credit.
  - Release condition: (credit reaches 0 on this beat) OR (i_req[owner] = 0).
  - If the release condition holds and i_lock[owner] = 0, release.
  - If the release condition holds and i_lock[owner] = 1, go to LOCKED.
- LOCKED:
  - hold_cnt increments every cycle. credit stays at 0; i_beat_done is ignored for credit.
  - If i_lock[owner] drops, release normally.
  - If hold_cnt reaches MAX_HOLD−1 with lock still high, force release and pulse o_lock_timeout.
- Release: ptr ← owner+1 (wrapping from NUM_CLIENTS−1 to 0), clear the grant, go to IDLE.
- i_cfg_load during a tenure updates the weight registers only. The current credit is unaffected; the new weights apply from the next tenure.
- i_beat_done in IDLE is ignored.
- Requests from non-owners never preempt the owner.
- Reset (asynchronous, at any point including mid-tenure):
  - o_gnt, o_gnt_id, o_busy, o_lock_timeout = 0.
  - State = IDLE, ptr = 0, every weight = 1.

## Timing
- Grant latency: i_req sampled at edge k in IDLE gives o_gnt/o_gnt_id/o_busy valid from edge k.
- Release decided on edge m drops o_gnt at edge m.
- The block always spends at least one IDLE cycle between tenures. The earliest next grant is at edge m+1.
- A weight-W tenure without lock lasts exactly until the edge that samples the W-th i_beat_done.
- Maximum LOCKED duration is MAX_HOLD cycles. o_lock_timeout is high for the one cycle following the forced-release edge.
- All outputs come straight from registers; there are no combinational input-to-output paths.

## Structure
- Package wrr_sched_pkg:
  - state enum type sched_state_e {IDLE, GRANT, LOCKED}.
  - Helper function for the modulo-NUM_CLIENTS pointer increment.
- Sub-module rr_pick: combinational rotating-priority encoder, (req, ptr) → (found, idx). It is instantiated once.

## Test plan
- Reset release, i_req=4'b0000 → all outputs stay 0. Then i_req=4'b0100 at edge k → o_gnt=4'b0100, o_gnt_id=2 from edge k.
- Weights {1,2,3,4}, all clients requesting, i_beat_done held at 1 → grant order 0,1,2,3,0 with tenure lengths 1,2,3,4 beats, one IDLE cycle between tenures.
- Client 1 owns the grant with weight 3 and drops i_req after 1 beat, lock low → release on that edge; next grant goes to client 2 (ptr=2).
- Client 0 with weight 1 holds i_lock=1 after its beat → state LOCKED; o_gnt stays 4'b0001; lock drops after 5 cycles → normal release, o_lock_timeout never pulses.
- Lock held indefinitely with MAX_HOLD=16 → forced release after 16 LOCKED cycles, o_lock_timeout pulses exactly once, next requester is granted afterwards.
- i_cfg_load with weight 0 for client 3 mid-tenure → the current tenure is unchanged; client 3's next tenure is 1 beat. rst_n asserted mid-LOCKED → outputs 0 immediately, ptr=0.
